if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline. Owns the PC register and the
//  instruction-memory request handshake, and drives the IF/ID pipeline register.
//  Selects next PC from PC+4, branch target (EX) or jump target (ID), honours
//  hazard-unit Stall/Flush, and buffers one in-flight fetch across stalls/redirects.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction word placed in IF/ID on bubble/flush
//  PC_STEP    32'd4          sequential PC increment
// PORTS
//  Clk           in   1   single clock, rising edge
//  RstN          in   1   asynchronous reset, active-low
//  Stall         in   1   hazard unit: hold PC and IF/ID
//  Flush         in   1   hazard unit: bubble IF/ID this cycle
//  BranchTaken   in   1   branch resolved taken (EX stage)
//  BranchTarget  in   32  branch target from branch-target adder
//  Jump          in   1   jump decoded (ID stage)
//  JumpTarget    in   32  jump target
//  ImemReq       out  1   fetch request valid
//  ImemAddr      out  32  fetch address (= Pc while ImemReq)
//  ImemReady     in   1   memory returns ImemData this cycle for the open request
//  ImemData      in   32  instruction word
//  Pc            out  32  current fetch PC
//  IfIdInstr     out  32  IF/ID instruction
//  IfIdPcPlus4   out  32  IF/ID PC+4 of that instruction
//  IfIdValid     out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (RstN=0, async): Pc=RESET_PC, state=IDLE, ImemReq=0, IfIdInstr=NOP_INSTR,
//   IfIdPcPlus4=0, IfIdValid=0, hold buffer empty, pending redirect cleared.
//  FSM: IDLE -> FETCH next cycle (one dead cycle after reset release, no request).
//   FETCH: ImemReq=!Stall, ImemAddr=Pc. If ImemReq&ImemReady -> completes same cycle,
//   stay FETCH. If ImemReq&!ImemReady -> WAIT. WAIT: ImemReq=1, ImemAddr stable
//   (Pc frozen) until ImemReady -> FETCH. No state returns to IDLE except reset.
//  Next-PC priority: BranchTaken > Jump > Stall(hold) > completion(Pc+PC_STEP) > hold.
//   Pc+PC_STEP is 32-bit wrap-around (0xFFFF_FFFC -> 0x0000_0000), no overflow flag.
//  Redirect in FETCH with no open request: Pc<=target next cycle, IF/ID bubbled.
//  Redirect in WAIT: target latched as pending; Pc unchanged until ImemReady; returned
//   word discarded (not written to IF/ID); Pc<=pending target on that edge.
//   Later redirect while pending overwrites pending target (same priority rule).
//  IF/ID update per edge: Flush or any redirect (incl. pending) -> Instr=NOP_INSTR,
//   Valid=0. Else Stall -> hold all three. Else completion (or hold buffer full) ->
//   Instr=word, PcPlus4=fetch Pc+PC_STEP, Valid=1. Else -> NOP_INSTR, Valid=0.
//  Hold buffer (1 entry): ImemReady arriving in WAIT while Stall=1 stores word+PcPlus4;
//   Pc advances. Drained into IF/ID on first non-Stall cycle; no new request issued
//   while buffer full. Flush/redirect empties it.
//  Stall and Flush together: Flush wins for IF/ID, Stall still holds Pc.
//  Latency: ImemReady at edge N -> IfIdValid=1 after edge N (0 extra cycles, unstalled).
// STRUCTURE
//  Shared package (pipeline_pkg): NOP_INSTR, PC_STEP, FSM state encoding
//   (IDLE/FETCH/WAIT), IF/ID field widths.
//  One sub-module: reuse the team's 32-bit Adder for Pc+PC_STEP; next-PC mux, FSM,
//   hold buffer and IF/ID register stay in this file.
// TESTING
//  Reset release, ImemReady tied 1 -> ImemAddr 0,4,8,C on consecutive cycles; IfIdPcPlus4 4,8,C.
//  ImemReady low 3 cycles at Pc=0x10 -> ImemAddr held 0x10, IfIdValid=0 for 3 cycles, then Instr.
//  BranchTaken=1, target 0x100, with Jump=1 target 0x200 same cycle -> next Pc=0x100, IfIdValid=0.
//  Jump to 0x40 during WAIT at Pc=0x20 -> returned word dropped, next ImemAddr=0x40.
//  Stall high 2 cycles while WAIT completes -> IF/ID held, word drained on Stall drop, no refetch.
//  RstN low mid-WAIT -> outputs at reset values asynchronously; Pc=0x0 ImemAddr fetch after IDLE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: IF-stage defaults, fetch FSM encoding and
// the IF/ID register layout.
package pipeline_pkg;

    localparam int          XLEN              = 32;
    localparam int          IFID_INSTR_W      = 32;
    localparam int          IFID_PC_W         = 32;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP   = 32'd4;

    // IDLE is only ever entered through reset.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    // One IF/ID slot; also the layout of the single-entry hold buffer.
    typedef struct packed {
        logic [IFID_INSTR_W-1:0] instr;
        logic [IFID_PC_W-1:0]    pc_plus4;
    } ifid_entry_t;

endpackage

// File: rtl/if_fetch_stage_adder.sv
// Plain W-bit adder with wrap-around; carry-out is intentionally dropped.
module if_fetch_stage_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake,
// next-PC selection, one-entry hold buffer and the IF/ID pipeline register.
//
// Memory handshake: ImemReq is the request valid and ImemAddr its address.
// A request completes on any rising edge where ImemReq && ImemReady; the word
// on ImemData belongs to that request. Once a request is left open across an
// edge (ImemReq && !ImemReady), ImemReq stays high and ImemAddr stays frozen
// until it completes; redirects arriving meanwhile are parked as pending.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
    parameter logic [31:0] PC_STEP   = DEFAULT_PC_STEP
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         Stall,
    input  logic         Flush,
    input  logic         BranchTaken,
    input  logic [31:0]  BranchTarget,
    input  logic         Jump,
    input  logic [31:0]  JumpTarget,
    output logic         ImemReq,
    output logic [31:0]  ImemAddr,
    input  logic         ImemReady,
    input  logic [31:0]  ImemData,
    output logic [31:0]  Pc,
    output logic [31:0]  IfIdInstr,
    output logic [31:0]  IfIdPcPlus4,
    output logic         IfIdValid,
    output fetch_state_e DbgState
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_pend_valid;
    logic [31:0]  r_pend_target;
    logic         r_hold_full;
    ifid_entry_t  r_hold;
    ifid_entry_t  r_ifid;
    logic         r_ifid_valid;

    logic [31:0]  w_pc_plus_step;
    logic         w_req;
    logic         w_redirect;
    logic [31:0]  w_redirect_target;
    logic         w_complete;
    logic         w_wait_done;
    logic         w_open_miss;
    logic         w_pend_fire;
    logic         w_any_redirect;
    logic [31:0]  w_pc_next;

    if_fetch_stage_adder #(.W(XLEN)) u_pc_adder (
        .i_a   (r_pc),
        .i_b   (PC_STEP),
        .o_sum (w_pc_plus_step)
    );

    // Branch (EX) outranks jump (ID) because it is the older instruction.
    assign w_redirect        = BranchTaken | Jump;
    assign w_redirect_target = BranchTaken ? BranchTarget : JumpTarget;

    // Request valid: never in IDLE, suppressed by Stall or a full hold buffer
    // in FETCH, and held high while an open request is outstanding.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_IDLE:  w_req = 1'b0;
            ST_FETCH: w_req = ~Stall & ~r_hold_full;
            ST_WAIT:  w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    assign w_complete     = w_req & ImemReady;
    assign w_wait_done    = (r_state == ST_WAIT) & ImemReady;
    assign w_open_miss    = w_req & ~ImemReady;
    assign w_pend_fire    = w_wait_done & r_pend_valid & ~w_redirect;
    assign w_any_redirect = w_redirect | (w_wait_done & r_pend_valid);

    // Next PC: an open request pins the address; otherwise branch > jump >
    // pending redirect > completion (a stalled WAIT completion still advances
    // because its word goes to the hold buffer) > hold.
    always_comb begin
        w_pc_next = r_pc;
        if (w_open_miss) begin
            w_pc_next = r_pc;
        end else if (w_redirect) begin
            w_pc_next = w_redirect_target;
        end else if (w_pend_fire) begin
            w_pc_next = r_pend_target;
        end else if (w_complete) begin
            w_pc_next = w_pc_plus_step;
        end
    end

    // Fetch FSM with PC and pending-redirect registers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                ST_IDLE:  r_state <= ST_FETCH;
                ST_FETCH: if (w_open_miss) r_state <= ST_WAIT;
                ST_WAIT:  if (ImemReady) r_state <= ST_FETCH;
                default:  r_state <= ST_IDLE;
            endcase
            if (w_open_miss && w_redirect) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_redirect_target;
            end else if (w_wait_done) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

    // Hold buffer: catches a word returning during Stall, drains when Stall drops.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_hold_full <= 1'b0;
            r_hold      <= '0;
        end else if (Flush || w_any_redirect) begin
            r_hold_full <= 1'b0;
        end else if (Stall && w_wait_done) begin
            r_hold_full    <= 1'b1;
            r_hold.instr   <= ImemData;
            r_hold.pc_plus4 <= w_pc_plus_step;
        end else if (!Stall) begin
            r_hold_full <= 1'b0;
        end
    end

    // IF/ID register: bubble on flush/redirect, hold on stall, else load.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_ifid.instr    <= NOP_INSTR;
            r_ifid.pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (Flush || w_any_redirect) begin
            r_ifid.instr    <= NOP_INSTR;
            r_ifid_valid    <= 1'b0;
        end else if (Stall) begin
            r_ifid_valid    <= r_ifid_valid;
        end else if (r_hold_full) begin
            r_ifid          <= r_hold;
            r_ifid_valid    <= 1'b1;
        end else if (w_complete) begin
            r_ifid.instr    <= ImemData;
            r_ifid.pc_plus4 <= w_pc_plus_step;
            r_ifid_valid    <= 1'b1;
        end else begin
            r_ifid.instr    <= NOP_INSTR;
            r_ifid_valid    <= 1'b0;
        end
    end

    assign ImemReq     = w_req;
    assign ImemAddr    = r_pc;
    assign Pc          = r_pc;
    assign IfIdInstr   = r_ifid.instr;
    assign IfIdPcPlus4 = r_ifid.pc_plus4;
    assign IfIdValid   = r_ifid_valid;
    assign DbgState    = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a word-per-address memory model, an
// expected queue of IF/ID entries, and immediate assertions at each check.
module tb_if_fetch_stage;
    import pipeline_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         stall, flush, br, jmp, ready;
    logic [31:0]  br_t, jmp_t;
    logic         imem_req;
    logic [31:0]  imem_addr, imem_data, pc, ifid_instr, ifid_pc4;
    logic         ifid_valid;
    fetch_state_e dbg_state;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  mon_e;
    logic         mon_stall;

    if_fetch_stage dut (
        .Clk          (clk),
        .RstN         (rst_n),
        .Stall        (stall),
        .Flush        (flush),
        .BranchTaken  (br),
        .BranchTarget (br_t),
        .Jump         (jmp),
        .JumpTarget   (jmp_t),
        .ImemReq      (imem_req),
        .ImemAddr     (imem_addr),
        .ImemReady    (ready),
        .ImemData     (imem_data),
        .Pc           (pc),
        .IfIdInstr    (ifid_instr),
        .IfIdPcPlus4  (ifid_pc4),
        .IfIdValid    (ifid_valid),
        .DbgState     (dbg_state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    assign imem_data = mem_word(imem_addr);

    // checks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic push(input logic [31:0] a);
        exp_q.push_back({mem_word(a), a + 32'd4});
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic r);
        @(negedge clk);
        stall = s; flush = f; br = b; br_t = bt; jmp = j; jmp_t = jt; ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: each newly loaded IF/ID entry must match the queue head
    always @(posedge clk) begin
        mon_stall = stall;
        #1;
        if (rst_n && ifid_valid && !mon_stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ifid", ifid_instr, DEFAULT_NOP_INSTR);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ifid_instr", ifid_instr, mon_e[63:32]);
                chk("ifid_pc4", ifid_pc4, mon_e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0;
        br_t = '0; jmp_t = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", ifid_valid, 1'b0);
        chk("rst_instr", ifid_instr, DEFAULT_NOP_INSTR);
        chk("rst_pc4", ifid_pc4, 32'h0);

        // release: one dead IDLE cycle, then sequential fetch with ready tied high
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        #1;
        chk1("idle_no_req", imem_req, 1'b0);
        tick();
        chk1("first_req", imem_req, 1'b1);
        chk1("dead_valid", ifid_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", imem_addr, 32'(4 * k));
            push(32'(4 * k));
            drive(0, 0, 0, '0, 0, '0, 1);
            tick();
        end

        // memory not ready for 3 cycles at 0x10
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, '0, 0, '0, 0);
            tick();
            chk("wait_addr", imem_addr, 32'h10);
            chk1("wait_req", imem_req, 1'b1);
            chk1("wait_valid", ifid_valid, 1'b0);
        end
        chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
        push(32'h10);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("after_wait_pc", pc, 32'h14);

        // branch and jump together: branch wins, IF/ID bubbled
        drive(0, 0, 1, 32'h100, 1, 32'h200, 1);
        tick();
        chk("br_pc", pc, 32'h100);
        chk1("br_bubble", ifid_valid, 1'b0);
        push(32'h100);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("br_next_pc", pc, 32'h104);

        // one stall cycle holds PC and a valid IF/ID
        drive(1, 0, 0, '0, 0, '0, 1);
        tick();
        chk("stall_pc", pc, 32'h104);
        chk1("stall_req", imem_req, 1'b0);
        chk1("stall_valid", ifid_valid, 1'b1);
        chk("stall_instr", ifid_instr, mem_word(32'h100));

        // jump to 0x40 while waiting at 0x20: returned word dropped
        drive(0, 0, 0, '0, 1, 32'h20, 1);
        tick();
        chk("j20_pc", pc, 32'h20);
        drive(0, 0, 0, '0, 0, '0, 0);
        tick();
        drive(0, 0, 0, '0, 1, 32'h40, 0);
        tick();
        chk("pend_addr_held", imem_addr, 32'h20);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("pend_addr", imem_addr, 32'h40);
        chk1("pend_drop", ifid_valid, 1'b0);
        push(32'h40);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();

        // stall two cycles while the WAIT at 0x44 completes
        drive(0, 0, 0, '0, 0, '0, 0);
        tick();
        push(32'h44);
        drive(1, 0, 0, '0, 0, '0, 1);
        tick();
        chk("hold_pc", pc, 32'h48);
        chk1("hold_req", imem_req, 1'b0);
        chk1("hold_valid", ifid_valid, 1'b0);
        drive(1, 0, 0, '0, 0, '0, 1);
        tick();
        chk("hold2_pc", pc, 32'h48);
        chk1("hold2_valid", ifid_valid, 1'b0);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("drain_pc", pc, 32'h48);
        chk1("drain_req", imem_req, 1'b1);
        push(32'h48);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("drain_next_pc", pc, 32'h4C);

        // PC wrap-around at the top of the address space
        drive(0, 0, 0, '0, 1, 32'hFFFF_FFFC, 1);
        tick();
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("wrap_pc", pc, 32'h0);

        // Stall and Flush together: IF/ID bubbled, PC held
        drive(1, 1, 0, '0, 0, '0, 1);
        tick();
        chk1("sf_valid", ifid_valid, 1'b0);
        chk("sf_instr", ifid_instr, DEFAULT_NOP_INSTR);
        chk("sf_pc", pc, 32'h0);

        // asynchronous reset in the middle of a WAIT
        push(32'h0);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        drive(0, 0, 0, '0, 0, '0, 0);
        tick();
        chk("pre_rst_addr", imem_addr, 32'h4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk1("arst_req", imem_req, 1'b0);
        chk1("arst_valid", ifid_valid, 1'b0);
        chk("arst_pc4", ifid_pc4, 32'h0);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rel_idle_req", imem_req, 1'b0);
        tick();
        chk("rel_addr", imem_addr, 32'h0);
        chk1("rel_req", imem_req, 1'b1);
        push(32'h0);
        drive(0, 0, 0, '0, 0, '0, 1);
        tick();
        chk("rel_next_pc", pc, 32'h4);

        drive(0, 0, 0, '0, 0, '0, 0);
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
